// File: rtl/block_streamer.sv
// Cuts a primary and a watermark image (external single-port RAMs) into MxM raster-order blocks
// and streams, per block, a 9-byte parameter header, M*M primary pixels and M*M watermark pixels.
module block_streamer #(
    parameter int Data_Depth    = 8,
    parameter int Addr_Width    = 19,
    parameter int Max_Block_Dim = 72,
    parameter int Img_Dim_Width = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [Img_Dim_Width-1:0] img_n,
    input  logic [Data_Depth-1:0]    cfg_white,
    input  logic [Data_Depth-1:0]    cfg_np,
    input  logic [Data_Depth-1:0]    cfg_nw,
    input  logic [Data_Depth-1:0]    cfg_m,
    input  logic [Data_Depth-1:0]    cfg_bthr,
    input  logic [Data_Depth-1:0]    cfg_amin,
    input  logic [Data_Depth-1:0]    cfg_amax,
    input  logic [Data_Depth-1:0]    cfg_bmin,
    input  logic [Data_Depth-1:0]    cfg_bmax,
    output logic                     prim_rd_en,
    output logic [Addr_Width-1:0]    prim_addr,
    input  logic [Data_Depth-1:0]    prim_data,
    output logic                     wm_rd_en,
    output logic [Addr_Width-1:0]    wm_addr,
    input  logic [Data_Depth-1:0]    wm_data,
    output logic [Data_Depth-1:0]    pixel_out,
    output logic                     pixel_valid,
    input  logic                     block_ack,
    output logic                     busy,
    output logic                     cfg_err,
    output logic                     done
);

    localparam int CNT_W = 13;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HDR      = 3'd1,
        S_PRIM     = 3'd2,
        S_WM       = 3'd3,
        S_WAIT_ACK = 3'd4,
        S_FIN      = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SRC_HOLD = 2'd0,
        SRC_PRIM = 2'd1,
        SRC_WM   = 2'd2
    } src_t;

    state_t                   state_r, state_nxt;
    src_t                     src_r, src_nxt;
    logic [3:0]               hdr_idx_r, hdr_idx_nxt;
    logic [CNT_W-1:0]         out_cnt_r, out_cnt_nxt;
    logic [CNT_W-1:0]         rd_idx_r, rd_idx_nxt;
    logic [CNT_W-1:0]         mm_last_s;
    logic [Data_Depth-1:0]    rd_c_r, rd_c_nxt, m_last_s;
    logic [Addr_Width-1:0]    rd_addr_r, rd_addr_nxt;
    logic [Addr_Width-1:0]    blk_base_r, blk_base_nxt, row_prod_s;
    logic [Img_Dim_Width-1:0] n_r, m_wide_s, row_next_s;
    logic [Img_Dim_Width-1:0] row_base_r, row_base_nxt, col_base_r, col_base_nxt;
    logic [Img_Dim_Width:0]   col_span_s, row_span_s;
    logic [Data_Depth-1:0]    white_r, np_r, nw_r, m_r, bthr_r, amin_r, amax_r, bmin_r, bmax_r;
    logic [Data_Depth-1:0]    hdr_next_byte_s, hold_r, hold_nxt, pixel_s;
    logic                     pixel_valid_r, pixel_valid_nxt;
    logic                     busy_r, busy_nxt, cfg_err_r, cfg_err_nxt, done_r, done_nxt;
    logic                     prim_rd_en_r, prim_rd_en_nxt, wm_rd_en_r, wm_rd_en_nxt;
    logic                     cfg_bad_s, cfg_load_s, rd_start_s, col_wrap_s, last_blk_s;

    // Block geometry: a new row of blocks starts when the next block would cross the right edge.
    assign m_wide_s   = Img_Dim_Width'(m_r);
    assign mm_last_s  = CNT_W'(m_r) * CNT_W'(m_r) - CNT_W'(1'b1);
    assign m_last_s   = m_r - Data_Depth'(1'b1);
    assign col_span_s = {1'b0, col_base_r} + {1'b0, m_wide_s} + {1'b0, m_wide_s};
    assign col_wrap_s = col_span_s > {1'b0, n_r};
    assign row_next_s = col_wrap_s ? (row_base_r + m_wide_s) : row_base_r;
    assign row_span_s = {1'b0, row_next_s} + {1'b0, m_wide_s};
    assign last_blk_s = row_span_s > {1'b0, n_r};
    assign row_prod_s = Addr_Width'(row_next_s) * Addr_Width'(n_r);
    assign cfg_bad_s  = (cfg_m == {Data_Depth{1'b0}}) ||
                        (cfg_m > Data_Depth'(Max_Block_Dim)) ||
                        (Img_Dim_Width'(cfg_m) > img_n);

    // Header byte that follows the one currently on pixel_out.
    always_comb begin
        case (hdr_idx_r)
            4'd0:    hdr_next_byte_s = np_r;
            4'd1:    hdr_next_byte_s = nw_r;
            4'd2:    hdr_next_byte_s = m_r;
            4'd3:    hdr_next_byte_s = bthr_r;
            4'd4:    hdr_next_byte_s = amin_r;
            4'd5:    hdr_next_byte_s = amax_r;
            4'd6:    hdr_next_byte_s = bmin_r;
            4'd7:    hdr_next_byte_s = bmax_r;
            default: hdr_next_byte_s = white_r;
        endcase
    end

    // RAM data is passed straight through so pixels follow the header with no bubble.
    always_comb begin
        case (src_r)
            SRC_PRIM: pixel_s = prim_data;
            SRC_WM:   pixel_s = wm_data;
            default:  pixel_s = hold_r;
        endcase
    end

    // Stream FSM: next state, counters and next values of the registered outputs.
    always_comb begin
        state_nxt       = state_r;
        src_nxt         = SRC_HOLD;
        hdr_idx_nxt     = hdr_idx_r;
        out_cnt_nxt     = out_cnt_r;
        row_base_nxt    = row_base_r;
        col_base_nxt    = col_base_r;
        blk_base_nxt    = blk_base_r;
        pixel_valid_nxt = 1'b0;
        busy_nxt        = busy_r;
        cfg_err_nxt     = cfg_err_r;
        done_nxt        = 1'b0;
        cfg_load_s      = 1'b0;
        rd_start_s      = 1'b0;
        if (pixel_valid_r) begin
            hold_nxt = pixel_s;
        end else begin
            hold_nxt = hold_r;
        end
        case (state_r)
            S_IDLE: begin
                if (start && cfg_bad_s) begin
                    cfg_err_nxt = 1'b1;
                end else if (start) begin
                    cfg_load_s      = 1'b1;
                    cfg_err_nxt     = 1'b0;
                    busy_nxt        = 1'b1;
                    state_nxt       = S_HDR;
                    hdr_idx_nxt     = 4'd0;
                    pixel_valid_nxt = 1'b1;
                    hold_nxt        = cfg_white;
                    row_base_nxt    = {Img_Dim_Width{1'b0}};
                    col_base_nxt    = {Img_Dim_Width{1'b0}};
                    blk_base_nxt    = {Addr_Width{1'b0}};
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_HDR: begin
                pixel_valid_nxt = 1'b1;
                if (hdr_idx_r == 4'd8) begin
                    state_nxt   = S_PRIM;
                    src_nxt     = SRC_PRIM;
                    out_cnt_nxt = {CNT_W{1'b0}};
                end else begin
                    hdr_idx_nxt = hdr_idx_r + 4'd1;
                    hold_nxt    = hdr_next_byte_s;
                    rd_start_s  = (hdr_idx_r == 4'd7);
                end
            end
            S_PRIM: begin
                pixel_valid_nxt = 1'b1;
                if (out_cnt_r == mm_last_s) begin
                    state_nxt   = S_WM;
                    src_nxt     = SRC_WM;
                    out_cnt_nxt = {CNT_W{1'b0}};
                end else begin
                    src_nxt     = SRC_PRIM;
                    out_cnt_nxt = out_cnt_r + CNT_W'(1'b1);
                end
            end
            S_WM: begin
                if (out_cnt_r == mm_last_s) begin
                    state_nxt = S_WAIT_ACK;
                end else begin
                    pixel_valid_nxt = 1'b1;
                    src_nxt         = SRC_WM;
                    out_cnt_nxt     = out_cnt_r + CNT_W'(1'b1);
                end
            end
            S_WAIT_ACK: begin
                if (block_ack && last_blk_s) begin
                    state_nxt = S_FIN;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                end else if (block_ack) begin
                    state_nxt       = S_HDR;
                    pixel_valid_nxt = 1'b1;
                    hold_nxt        = white_r;
                    hdr_idx_nxt     = 4'd0;
                    row_base_nxt    = row_next_s;
                    col_base_nxt    = col_wrap_s ? {Img_Dim_Width{1'b0}} : (col_base_r + m_wide_s);
                    blk_base_nxt    = col_wrap_s ? row_prod_s : (blk_base_r + Addr_Width'(m_r));
                end else begin
                    state_nxt = S_WAIT_ACK;
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Read sequencer: 2*M*M back-to-back reads, primary block first, then the same addresses on wm.
    always_comb begin
        prim_rd_en_nxt = 1'b0;
        wm_rd_en_nxt   = 1'b0;
        rd_idx_nxt     = rd_idx_r;
        rd_c_nxt       = rd_c_r;
        rd_addr_nxt    = rd_addr_r;
        if (rd_start_s) begin
            prim_rd_en_nxt = 1'b1;
            rd_idx_nxt     = {CNT_W{1'b0}};
            rd_c_nxt       = {Data_Depth{1'b0}};
            rd_addr_nxt    = blk_base_r;
        end else if ((prim_rd_en_r || wm_rd_en_r) && (rd_idx_r == mm_last_s)) begin
            wm_rd_en_nxt = prim_rd_en_r;
            rd_idx_nxt   = {CNT_W{1'b0}};
            rd_c_nxt     = {Data_Depth{1'b0}};
            rd_addr_nxt  = blk_base_r;
        end else if (prim_rd_en_r || wm_rd_en_r) begin
            prim_rd_en_nxt = prim_rd_en_r;
            wm_rd_en_nxt   = wm_rd_en_r;
            rd_idx_nxt     = rd_idx_r + CNT_W'(1'b1);
            if (rd_c_r == m_last_s) begin
                rd_c_nxt    = {Data_Depth{1'b0}};
                rd_addr_nxt = rd_addr_r + Addr_Width'(n_r) - Addr_Width'(m_r) + Addr_Width'(1'b1);
            end else begin
                rd_c_nxt    = rd_c_r + Data_Depth'(1'b1);
                rd_addr_nxt = rd_addr_r + Addr_Width'(1'b1);
            end
        end else begin
            rd_idx_nxt = rd_idx_r;
        end
    end

    // FSM state and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            src_r      <= SRC_HOLD;
            hdr_idx_r  <= 4'd0;
            out_cnt_r  <= {CNT_W{1'b0}};
            row_base_r <= {Img_Dim_Width{1'b0}};
            col_base_r <= {Img_Dim_Width{1'b0}};
            blk_base_r <= {Addr_Width{1'b0}};
            rd_idx_r   <= {CNT_W{1'b0}};
            rd_c_r     <= {Data_Depth{1'b0}};
        end else begin
            state_r    <= state_nxt;
            src_r      <= src_nxt;
            hdr_idx_r  <= hdr_idx_nxt;
            out_cnt_r  <= out_cnt_nxt;
            row_base_r <= row_base_nxt;
            col_base_r <= col_base_nxt;
            blk_base_r <= blk_base_nxt;
            rd_idx_r   <= rd_idx_nxt;
            rd_c_r     <= rd_c_nxt;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_r        <= {Data_Depth{1'b0}};
            pixel_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            cfg_err_r     <= 1'b0;
            done_r        <= 1'b0;
            prim_rd_en_r  <= 1'b0;
            wm_rd_en_r    <= 1'b0;
            rd_addr_r     <= {Addr_Width{1'b0}};
        end else begin
            hold_r        <= hold_nxt;
            pixel_valid_r <= pixel_valid_nxt;
            busy_r        <= busy_nxt;
            cfg_err_r     <= cfg_err_nxt;
            done_r        <= done_nxt;
            prim_rd_en_r  <= prim_rd_en_nxt;
            wm_rd_en_r    <= wm_rd_en_nxt;
            rd_addr_r     <= rd_addr_nxt;
        end
    end

    // Configuration captured on an accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_r     <= {Img_Dim_Width{1'b0}};
            white_r <= {Data_Depth{1'b0}};
            np_r    <= {Data_Depth{1'b0}};
            nw_r    <= {Data_Depth{1'b0}};
            m_r     <= {Data_Depth{1'b0}};
            bthr_r  <= {Data_Depth{1'b0}};
            amin_r  <= {Data_Depth{1'b0}};
            amax_r  <= {Data_Depth{1'b0}};
            bmin_r  <= {Data_Depth{1'b0}};
            bmax_r  <= {Data_Depth{1'b0}};
        end else if (cfg_load_s) begin
            n_r     <= img_n;
            white_r <= cfg_white;
            np_r    <= cfg_np;
            nw_r    <= cfg_nw;
            m_r     <= cfg_m;
            bthr_r  <= cfg_bthr;
            amin_r  <= cfg_amin;
            amax_r  <= cfg_amax;
            bmin_r  <= cfg_bmin;
            bmax_r  <= cfg_bmax;
        end else begin
            n_r <= n_r;
        end
    end

    assign prim_rd_en  = prim_rd_en_r;
    assign wm_rd_en    = wm_rd_en_r;
    assign prim_addr   = rd_addr_r;
    assign wm_addr     = rd_addr_r;
    assign pixel_out   = pixel_s;
    assign pixel_valid = pixel_valid_r;
    assign busy        = busy_r;
    assign cfg_err     = cfg_err_r;
    assign done        = done_r;

endmodule

// File: tb/tb_block_streamer.sv
// Directed bench for block_streamer: table of image/block configurations plus hand-written
// sequences for the exact first-block stream, ignored inputs and mid-stream reset.
module tb_block_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  img_n = 10'd0;
    logic [7:0]  cfg_white = 8'd0, cfg_np = 8'd0, cfg_nw = 8'd0, cfg_m = 8'd0, cfg_bthr = 8'd0;
    logic [7:0]  cfg_amin = 8'd0, cfg_amax = 8'd0, cfg_bmin = 8'd0, cfg_bmax = 8'd0;
    logic        prim_rd_en, wm_rd_en;
    logic [18:0] prim_addr, wm_addr, mon_addr;
    logic [7:0]  prim_data = 8'd0, wm_data = 8'd0, pixel_out;
    logic        pixel_valid, block_ack = 1'b0, busy, cfg_err, done;

    block_streamer dut (
        .clk(clk), .rst(rst), .start(start), .img_n(img_n),
        .cfg_white(cfg_white), .cfg_np(cfg_np), .cfg_nw(cfg_nw), .cfg_m(cfg_m),
        .cfg_bthr(cfg_bthr), .cfg_amin(cfg_amin), .cfg_amax(cfg_amax),
        .cfg_bmin(cfg_bmin), .cfg_bmax(cfg_bmax),
        .prim_rd_en(prim_rd_en), .prim_addr(prim_addr), .prim_data(prim_data),
        .wm_rd_en(wm_rd_en), .wm_addr(wm_addr), .wm_data(wm_data),
        .pixel_out(pixel_out), .pixel_valid(pixel_valid), .block_ack(block_ack),
        .busy(busy), .cfg_err(cfg_err), .done(done)
    );

    always #5 clk = ~clk;

    // RAM models: prim[a] = a, wm[a] = 0x80 + a (low byte), one cycle read latency.
    always @(posedge clk) begin
        if (prim_rd_en) prim_data <= prim_addr[7:0];
        if (wm_rd_en)   wm_data   <= 8'h80 + wm_addr[7:0];
    end

    int total = 0, bad = 0;
    int done_cnt = 0, valid_cnt = 0, viol_cnt = 0;
    int cur_n = 4, cur_lim = 4;
    logic [7:0] burst_q[$];
    logic [7:0] exp_q[$];

    assign mon_addr = prim_rd_en ? prim_addr : wm_addr;

    // Event counters and read-address window monitor.
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (pixel_valid) valid_cnt <= valid_cnt + 1;
        if ((prim_rd_en || wm_rd_en) &&
            (((int'(mon_addr) % cur_n) >= cur_lim) || ((int'(mon_addr) / cur_n) >= cur_lim)))
            viol_cnt <= viol_cnt + 1;
    end

    typedef struct packed {
        logic [9:0]       n;
        logic [7:0]       m;
        logic             err;
        logic [7:0]       nblk;
        logic [3:0][15:0] base;
    } vec_t;

    vec_t vecs [9];
    logic [7:0] exp17 [17];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_img(input int n, input int m);
        @(negedge clk);
        img_n = 10'(n);
        cfg_white = 8'd1; cfg_np = 8'd2; cfg_nw = 8'd3; cfg_m = 8'(m); cfg_bthr = 8'd5;
        cfg_amin = 8'd6; cfg_amax = 8'd7; cfg_bmin = 8'd8; cfg_bmax = 8'd9;
        cur_n = n;
        cur_lim = (m > 0) ? (n / m) * m : n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic get_burst();
        int k = 0;
        burst_q.delete();
        while (!pixel_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!pixel_valid) begin
            total++; bad++;
            $display("FAIL burst_timeout: got no pixel_valid within %0d cycles", k);
        end
        while (pixel_valid && burst_q.size() < 12000) begin
            burst_q.push_back(pixel_out);
            @(negedge clk);
        end
    endtask

    task automatic ack_block(input int dly);
        repeat (dly) @(negedge clk);
        block_ack = 1'b1;
        @(negedge clk);
        block_ack = 1'b0;
    endtask

    task automatic build_exp(input int n, input int m, input int base);
        int a;
        exp_q.delete();
        exp_q.push_back(8'd1); exp_q.push_back(8'd2); exp_q.push_back(8'd3);
        exp_q.push_back(8'(m)); exp_q.push_back(8'd5); exp_q.push_back(8'd6);
        exp_q.push_back(8'd7); exp_q.push_back(8'd8); exp_q.push_back(8'd9);
        for (int r = 0; r < m; r++)
            for (int c = 0; c < m; c++) begin
                a = base + r * n + c;
                exp_q.push_back(8'(a));
            end
        for (int r = 0; r < m; r++)
            for (int c = 0; c < m; c++) begin
                a = base + r * n + c;
                exp_q.push_back(8'(128 + a));
            end
    endtask

    task automatic cmp_burst(input string name);
        int first = -1;
        total++;
        if (burst_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s length: got %0d expected %0d", name, burst_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++)
                if (first < 0 && burst_q[i] !== exp_q[i]) first = i;
            if (first >= 0) begin
                bad++;
                $display("FAIL %s byte %0d: got %0h expected %0h", name, first,
                         burst_q[first], exp_q[first]);
            end
        end
    endtask

    task automatic cmp17(input string name);
        check({name, "_len"}, burst_q.size(), 17);
        for (int i = 0; i < 17 && i < burst_q.size(); i++)
            check(name, int'(burst_q[i]), int'(exp17[i]));
    endtask

    task automatic drain(input int nrem);
        ack_block(3);
        for (int i = 0; i < nrem; i++) begin
            get_burst();
            ack_block(3);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, v0, x0;
        exp17 = '{8'd1, 8'd2, 8'd3, 8'd2, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9,
                  8'd0, 8'd1, 8'd4, 8'd5, 8'h80, 8'h81, 8'h84, 8'h85};
        vecs[0] = '{10'd4,  8'd0,  1'b1, 8'd0, 64'd0};
        vecs[1] = '{10'd4,  8'd73, 1'b1, 8'd0, 64'd0};
        vecs[2] = '{10'd4,  8'd8,  1'b1, 8'd0, 64'd0};
        vecs[3] = '{10'd4,  8'd2,  1'b0, 8'd4, {16'd10, 16'd8,  16'd2, 16'd0}};
        vecs[4] = '{10'd5,  8'd2,  1'b0, 8'd4, {16'd12, 16'd10, 16'd2, 16'd0}};
        vecs[5] = '{10'd3,  8'd3,  1'b0, 8'd1, 64'd0};
        vecs[6] = '{10'd2,  8'd1,  1'b0, 8'd4, {16'd3,  16'd2,  16'd1, 16'd0}};
        vecs[7] = '{10'd6,  8'd3,  1'b0, 8'd4, {16'd21, 16'd18, 16'd3, 16'd0}};
        vecs[8] = '{10'd72, 8'd72, 1'b0, 8'd1, 64'd0};

        repeat (3) @(negedge clk);
        check("rst_pixel_out", pixel_out, 0);
        check("rst_pixel_valid", pixel_valid, 0);
        check("rst_strobes", {prim_rd_en, wm_rd_en}, 0);
        check("rst_addrs", int'(prim_addr) + int'(wm_addr), 0);
        check("rst_flags", {busy, cfg_err, done}, 0);
        rst = 1'b1;

        for (int v = 0; v < 9; v++) begin
            d0 = done_cnt; v0 = valid_cnt; x0 = viol_cnt;
            start_img(int'(vecs[v].n), int'(vecs[v].m));
            if (vecs[v].err) begin
                check("err_flag", cfg_err, 1);
                check("err_busy", busy, 0);
                repeat (20) @(negedge clk);
                check("err_no_stream", valid_cnt - v0, 0);
                check("err_sticky", cfg_err, 1);
            end else begin
                check("ok_err_clear", cfg_err, 0);
                check("ok_busy", busy, 1);
                check("ok_first_hdr", {pixel_valid, pixel_out}, {1'b1, 8'd1});
                for (int b = 0; b < int'(vecs[v].nblk); b++) begin
                    get_burst();
                    build_exp(int'(vecs[v].n), int'(vecs[v].m), int'(vecs[v].base[b]));
                    cmp_burst("blk_stream");
                    ack_block(3);
                    if (b == int'(vecs[v].nblk) - 1) begin
                        check("done_after_ack", done, 1);
                        check("busy_drop", busy, 0);
                    end else begin
                        check("no_early_done", done, 0);
                    end
                end
                repeat (2) @(negedge clk);
                check("done_once", done_cnt - d0, 1);
                check("addr_window", viol_cnt - x0, 0);
                check("idle_after", {busy, done}, 0);
            end
        end

        // Exact first-block stream, N=4 M=2.
        start_img(4, 2);
        get_burst();
        cmp17("s1_byte");
        drain(3);

        // block_ack and start during the burst must not disturb it.
        start_img(4, 2);
        burst_q.delete();
        for (int k = 0; pixel_valid && k < 40; k++) begin
            burst_q.push_back(pixel_out);
            if (k == 4 || k == 12) begin
                block_ack = 1'b1; start = 1'b1; cfg_m = 8'd3;
            end else begin
                block_ack = 1'b0; start = 1'b0;
            end
            @(negedge clk);
        end
        block_ack = 1'b0; start = 1'b0; cfg_m = 8'd2;
        cmp17("s5_byte");
        check("s5_waiting", {pixel_valid, busy}, 2'b01);
        ack_block(3);
        get_burst();
        build_exp(4, 2, 2);
        cmp_burst("s5_blk1");
        drain(2);

        // Reset in the middle of block 1 primary pixels.
        start_img(4, 2);
        get_burst();
        ack_block(3);
        repeat (11) @(negedge clk);
        check("s6_in_prim", pixel_valid, 1);
        rst = 1'b0;
        #1;
        check("s6_rst_valid", pixel_valid, 0);
        check("s6_rst_pixel", pixel_out, 0);
        check("s6_rst_rd", {prim_rd_en, wm_rd_en}, 0);
        check("s6_rst_addr", int'(prim_addr), 0);
        check("s6_rst_flags", {busy, done, cfg_err}, 0);
        @(negedge clk);
        rst = 1'b1;
        start_img(4, 2);
        get_burst();
        cmp17("s6_restart");
        d0 = done_cnt;
        drain(3);
        repeat (2) @(negedge clk);
        check("s6_done_once", done_cnt - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
